// File: rtl/spart_tx.sv
// Serial transmitter: one-byte holding register feeding a shift register,
// framed as start bit, 8 data bits LSB first, stop bit, paced by tx_enable ticks.
module spart_tx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_enable,
  input  logic       write,
  input  logic [7:0] tx_data,
  output logic       txd,
  output logic       tbr,
  output logic       busy,
  output logic       tx_overrun
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

  state_t     state_reg;
  logic [7:0] hold_buf_reg;
  logic       hold_full_reg;
  logic [7:0] shift_reg;
  logic [3:0] tick_reg;
  logic [2:0] bit_idx_reg;

  logic bit_end;
  logic load;
  logic accept;
  logic hold_full_next;

  always_comb begin
    bit_end        = tx_enable && (tick_reg == TICK_LAST) && (state_reg != IDLE);
    // A waiting byte goes out immediately from IDLE, or back-to-back at stop end
    load           = hold_full_reg &&
                     ((state_reg == IDLE) || ((state_reg == STOP) && bit_end));
    accept         = write && tbr;
    hold_full_next = accept || (hold_full_reg && !load);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      hold_buf_reg  <= 8'h00;
      hold_full_reg <= 1'b0;
      shift_reg     <= 8'hFF;
      tick_reg      <= 4'd0;
      bit_idx_reg   <= 3'd0;
      txd           <= 1'b1;
      tbr           <= 1'b1;
      busy          <= 1'b0;
      tx_overrun    <= 1'b0;
    end else begin
      hold_full_reg <= hold_full_next;
      tbr           <= !hold_full_next;
      if (accept)
        hold_buf_reg <= tx_data;
      if (write && !tbr)
        tx_overrun <= 1'b1;

      if (load) begin
        shift_reg   <= hold_buf_reg;
        tick_reg    <= 4'd0;
        bit_idx_reg <= 3'd0;
        state_reg   <= START;
        txd         <= 1'b0;
        busy        <= 1'b1;
      end else if ((state_reg != IDLE) && tx_enable) begin
        tick_reg <= bit_end ? 4'd0 : tick_reg + 4'd1;
        if (bit_end) begin
          case (state_reg)
            START: begin
              state_reg   <= DATA;
              bit_idx_reg <= 3'd0;
              txd         <= shift_reg[0];
            end
            DATA: begin
              shift_reg   <= {1'b1, shift_reg[7:1]};
              bit_idx_reg <= bit_idx_reg + 3'd1;
              if (bit_idx_reg == 3'd7) begin
                state_reg <= STOP;
                txd       <= 1'b1;
              end else begin
                txd <= shift_reg[1];
              end
            end
            STOP: begin
              state_reg <= IDLE;
              txd       <= 1'b1;
              busy      <= 1'b0;
            end
            default: begin
              state_reg <= IDLE;
              txd       <= 1'b1;
              busy      <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spart_tx.sv
// Bench for spart_tx: frame-level reference model checked every cycle,
// table-driven single frames, and directed multi-cycle corner sequences.
module tb_spart_tx;
  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_enable = 1'b0;
  logic       write = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       txd, tbr, busy, tx_overrun;

  spart_tx #(.OVERSAMPLE(OS)) dut (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .write(write),
    .tx_data(tx_data), .txd(txd), .tbr(tbr), .busy(busy), .tx_overrun(tx_overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Baud tick generator: one pulse every en_period clocks, pausable
  int en_period = 40;
  bit en_gate = 1'b1;
  int en_cnt = 0;
  always @(negedge clk) begin
    if (en_gate && en_cnt >= en_period - 1) begin
      tx_enable = 1'b1;
      en_cnt = 0;
    end else begin
      tx_enable = 1'b0;
      if (en_gate) en_cnt++;
    end
  end

  int unsigned pulse_cnt = 0;
  int unsigned cyc = 0;
  always @(posedge clk) begin
    cyc++;
    if (tx_enable) pulse_cnt++;
  end

  // Reference model: a frame is a 10-bit vector played out over 10*OS ticks
  bit         m_hold_full = 1'b0;
  bit         m_active = 1'b0;
  bit         m_ovr = 1'b0;
  logic [7:0] m_hold = 8'h00;
  logic [9:0] m_frame = '1;
  int         m_left = 0;

  always @(posedge clk or posedge rst) begin
    bit ld, hf0;
    if (rst) begin
      m_hold_full = 1'b0;
      m_active = 1'b0;
      m_ovr = 1'b0;
      m_left = 0;
    end else begin
      hf0 = m_hold_full;
      ld = m_hold_full && (!m_active || (tx_enable && m_left == 1));
      if (m_active && tx_enable) begin
        m_left--;
        if (m_left == 0) m_active = 1'b0;
      end
      if (ld) begin
        m_frame = {1'b1, m_hold, 1'b0};
        m_left = 10 * OS;
        m_active = 1'b1;
        m_hold_full = 1'b0;
      end
      if (write) begin
        if (hf0) m_ovr = 1'b1;
        else begin
          m_hold = tx_data;
          m_hold_full = 1'b1;
        end
      end
    end
  end

  function automatic logic m_txd();
    int idx;
    if (!m_active) return 1'b1;
    idx = (10 * OS - m_left) / OS;
    return m_frame[idx];
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ({txd, busy, tbr, tx_overrun} !== {m_txd(), m_active, !m_hold_full, m_ovr}) begin
        errors++;
        $display("FAIL model txd/busy/tbr/ovr: got %b%b%b%b expected %b%b%b%b at cycle %0d",
                 txd, busy, tbr, tx_overrun, m_txd(), m_active, !m_hold_full, m_ovr, cyc);
      end
    end
  end

  bit watch_busy = 1'b0;
  int busy_gaps = 0;
  always @(negedge clk) if (watch_busy && !busy) busy_gaps++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out, got no event expected one", name);
  endtask

  task automatic do_write(input logic [7:0] d);
    write = 1'b1;
    tx_data = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic wait_pulses_to(input int unsigned target);
    int n = 0;
    while (pulse_cnt < target) begin
      @(negedge clk);
      n++;
      if (n > 20000) begin
        timeout("wait_pulses");
        return;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy) begin
      @(negedge clk);
      n++;
      if (n > 20000) begin
        timeout(name);
        return;
      end
    end
  endtask

  // Sample each bit mid-period, counting ticks from the frame start
  task automatic decode_from(input int unsigned base, input logic [9:0] exp,
                             input string tag, input int gate);
    int bad;
    for (int k = 0; k < 10; k++) begin
      if (k == 0 && gate > 0) begin
        wait_pulses_to(base + 5);
        en_gate = 1'b0;
        bad = 0;
        for (int g = 0; g < gate; g++) begin
          @(negedge clk);
          if (txd !== 1'b0) bad++;
        end
        chk({tag, "_gate_hold"}, bad, 0);
        en_gate = 1'b1;
      end
      wait_pulses_to(base + 16 * k + 8);
      chk($sformatf("%s_bit%0d", tag, k), txd, exp[k]);
    end
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    int         period;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int unsigned base;
    int unsigned t0;
    int dur;

    tbl[0] = '{8'h88, 10'b1100010000, 40};
    tbl[1] = '{8'h0F, 10'b1000011110, 4};
    tbl[2] = '{8'hF0, 10'b1111100000, 4};
    tbl[3] = '{8'h5A, 10'b1010110100, 2};
    tbl[4] = '{8'hA5, 10'b1101001010, 1};

    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_tbr", tbr, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", tx_overrun, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Table: single frames at several tick rates
    for (int i = 0; i < 5; i++) begin
      en_period = tbl[i].period;
      repeat (2) @(negedge clk);
      chk($sformatf("t%0d_idle_busy", i), busy, 0);
      do_write(tbl[i].data);
      chk($sformatf("t%0d_tbr_low", i), tbr, 0);
      @(negedge clk);
      chk($sformatf("t%0d_tbr_back", i), tbr, 1);
      chk($sformatf("t%0d_start", i), {busy, txd}, 2'b10);
      base = pulse_cnt;
      t0 = cyc;
      decode_from(base, tbl[i].frame, $sformatf("t%0d", i), 0);
      wait_idle("table_idle");
      dur = int'(cyc - t0);
      checks++;
      if (dur < 159 * tbl[i].period + 1 || dur > 160 * tbl[i].period) begin
        errors++;
        $display("FAIL t%0d_busy_len: got %0d clks expected %0d..%0d",
                 i, dur, 159 * tbl[i].period + 1, 160 * tbl[i].period);
      end
    end

    // Back-to-back frames with no idle gap
    en_period = 40;
    do_write(8'h55);
    @(negedge clk);
    base = pulse_cnt;
    watch_busy = 1'b1;
    busy_gaps = 0;
    do_write(8'hA3);
    decode_from(base, frame_of(8'h55), "b2b_a", 0);
    wait_pulses_to(base + 160);
    chk("b2b_second_start", {busy, txd}, 2'b10);
    decode_from(base + 160, frame_of(8'hA3), "b2b_b", 0);
    watch_busy = 1'b0;
    chk("b2b_busy_gaps", busy_gaps, 0);
    wait_idle("b2b_idle");

    // Overrun: third write while the holding register is full
    en_period = 4;
    do_write(8'h01);
    @(negedge clk);
    base = pulse_cnt;
    do_write(8'h02);
    chk("ovr_before", tx_overrun, 0);
    do_write(8'h03);
    chk("ovr_set", tx_overrun, 1);
    decode_from(base, frame_of(8'h01), "ovr_a", 0);
    wait_pulses_to(base + 160);
    decode_from(base + 160, frame_of(8'h02), "ovr_b", 0);
    wait_idle("ovr_idle");
    repeat (200) @(negedge clk);
    chk("ovr_no_third", {busy, txd}, 2'b01);
    chk("ovr_sticky", tx_overrun, 1);

    // Write on the same cycle as the hold-to-shift transfer is discarded
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("same_ovr_cleared", tx_overrun, 0);
    do_write(8'h3C);
    do_write(8'hC3);
    chk("same_ovr_set", tx_overrun, 1);
    chk("same_tbr", tbr, 1);
    chk("same_start", txd, 0);
    base = pulse_cnt;
    decode_from(base, frame_of(8'h3C), "same", 0);
    wait_idle("same_idle");
    repeat (200) @(negedge clk);
    chk("same_no_second", busy, 0);

    // Reset mid-frame during data bit 3, with a byte waiting in hold
    do_write(8'hF0);
    @(negedge clk);
    base = pulse_cnt;
    do_write(8'h77);
    wait_pulses_to(base + 4 * 16 + 8);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_txd", txd, 1);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_tbr", tbr, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("rstmid_quiet", {busy, txd}, 2'b01);
    do_write(8'h0F);
    @(negedge clk);
    base = pulse_cnt;
    decode_from(base, frame_of(8'h0F), "rstmid_clean", 0);
    wait_idle("rstmid_idle");

    // Tick gating in the middle of the start bit
    do_write(8'hC5);
    @(negedge clk);
    base = pulse_cnt;
    decode_from(base, frame_of(8'hC5), "gate", 1000);
    wait_idle("gate_idle");

    // Random writes and occasional resets against the reference model
    for (int c = 0; c < 8000; c++) begin
      if (c % 2000 == 0) en_period = 1 + int'($urandom_range(0, 3));
      write = ($urandom_range(0, 59) == 0);
      tx_data = 8'($urandom);
      if ($urandom_range(0, 2999) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
      @(negedge clk);
    end
    write = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected finish before 900000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
